pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter generator: it owns the PC register and selects between sequential advance, any of NUM_REDIRECT prioritised redirect channels, and one buffered redirect that was captured while fetch was stalled.
- It sits at the head of fetch, replaces the single-source PC select, and drives the instruction-memory address.
- Redirect channels come from later pipeline stages (branch, jump, exception). Channel 0 has the highest priority.

Parameters:
- PC_WIDTH, 16, width of the PC and of every redirect address.
- PC_STEP, 3, sequential increment added to the PC each advancing cycle.
- NUM_REDIRECT, 2, number of redirect channels; minimum 1.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous reset, active-high.
- Stall  input  1  when high, PC_Out holds its value.
- Redirect_Valid  input  NUM_REDIRECT  bit i high means channel i requests a redirect this cycle.
- Redirect_Address  input  NUM_REDIRECT*PC_WIDTH  flattened targets; channel i occupies bits [i*PC_WIDTH +: PC_WIDTH].
- PC_Out  output  PC_WIDTH  registered current PC.
- PC_Next  output  PC_WIDTH  combinational value PC_Out will take at the next edge.
- PC_Valid  output  1  registered; PC_Out is a fetchable address.
- Redirect_Pending  output  1  registered; a buffered redirect is held.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high and has priority over every other input.
- Reset values: PC_Out=RESET_PC, PC_Valid=0, Redirect_Pending=0, pending address=0, FSM=START.
- FSM states: START, RUN.
  - START, at the next edge with Reset low:
    - go to RUN and set PC_Valid<=1;
    - PC_Out holds RESET_PC, and Stall is ignored;
    - any redirect presented in START is captured into the pending buffer (highest-priority valid channel).
  - RUN: stays in RUN until Reset.
- Selection: sel = lowest index i with Redirect_Valid[i]=1. any_redir = OR of Redirect_Valid.
- RUN, Stall=0, next PC in priority order:
  1. Redirect_Pending=1: PC_Out<=pending address and Redirect_Pending<=0. Live redirects in the same cycle are discarded, because the older redirect squashes the younger path.
  2. Otherwise, any_redir=1: PC_Out<=Redirect_Address[sel].
  3. Otherwise: PC_Out<=PC_Out+PC_STEP, truncated to PC_WIDTH (wraps modulo 2^PC_WIDTH).
- RUN, Stall=1:
  - PC_Out holds.
  - If any_redir=1 and Redirect_Pending=0: capture Redirect_Address[sel] and set Redirect_Pending<=1.
  - If Redirect_Pending=1: the held address is kept and new redirects are discarded (older wins).
- PC_Next follows exactly the rules above for the current inputs; it equals PC_Out when stalled or in START. No latency beyond the single PC register.
- PC_Valid stays 1 in RUN, including while stalled; the consumer qualifies fetch with Stall.
- Reset mid-operation: the pending redirect is dropped and PC_Out returns to RESET_PC on that edge.
- Redirect_Address on channels whose valid bit is low is ignored; X on those channels must not propagate to the outputs.

Test Plan:
- Reset sequence: Reset high 2 cycles, then low, no stall or redirect -> PC_Out=0 with PC_Valid 0 during reset; PC_Out=0 with PC_Valid 1 on the first post-reset cycle; then 3, 6, 9.
- Wrap-around: force the sequence to reach PC_Out=0xFFFE -> next PC_Out=0x0001.
- Priority: in RUN, Redirect_Valid=2'b11 with ch0=0x0100 and ch1=0x0200 -> PC_Out=0x0100 next cycle. Repeat with Redirect_Valid=2'b10 -> PC_Out=0x0200.
- Stall buffering:
  - with PC_Out=0x0030, assert Stall for 3 cycles with a ch1 redirect to 0x0400 on stall cycle 1 and a ch0 redirect to 0x0500 on stall cycle 2;
  - required: PC_Out holds 0x0030 and Redirect_Pending=1 from stall cycle 2 onward;
  - after Stall drops, PC_Out=0x0400 with Redirect_Pending=0, followed by 0x0403.
- Pending vs live: pending holds 0x0400, Stall drops in the same cycle a ch0 redirect to 0x0600 arrives -> PC_Out=0x0400 and the live redirect is discarded.
- Reset mid-stall with a pending redirect -> Redirect_Pending=0 and PC_Out=RESET_PC next edge. After release, the old pending target never appears on PC_Out.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle for the PC sequencer: stall/redirect requests in,
// current/next PC and status out.
interface pc_sequencer_if #(
  parameter int PC_WIDTH     = 16,
  parameter int NUM_REDIRECT = 2
);
  logic                             Stall;
  logic [NUM_REDIRECT-1:0]          Redirect_Valid;
  logic [NUM_REDIRECT*PC_WIDTH-1:0] Redirect_Address;
  logic [PC_WIDTH-1:0]              PC_Out;
  logic [PC_WIDTH-1:0]              PC_Next;
  logic                             PC_Valid;
  logic                             Redirect_Pending;

  modport master (
    output Stall, Redirect_Valid, Redirect_Address,
    input  PC_Out, PC_Next, PC_Valid, Redirect_Pending
  );

  modport slave (
    input  Stall, Redirect_Valid, Redirect_Address,
    output PC_Out, PC_Next, PC_Valid, Redirect_Pending
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter generator: sequential advance, prioritised redirects, one buffered redirect.
// Latency: one register; PC_Next is the combinational value PC_Out takes at the next edge.
// Backpressure: Stall holds the PC; one redirect seen while stalled is buffered, the oldest wins.
module pc_sequencer #(
  parameter int                PC_WIDTH     = 16,
  parameter int                PC_STEP      = 3,
  parameter int                NUM_REDIRECT = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input logic            Clk,
  input logic            Reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic {START, RUN} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pend_addr;
  logic                pend_vld;
  logic                pc_vld;

  logic                any_redir;
  logic [PC_WIDTH-1:0] sel_addr;
  logic [PC_WIDTH-1:0] pc_next;

  // Walk from the lowest priority upward so channel 0 wins; addresses of
  // invalid channels are never read, so X there cannot leak out.
  always_comb begin
    any_redir = 1'b0;
    sel_addr  = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (bus.Redirect_Valid[i]) begin
        any_redir = 1'b1;
        sel_addr  = bus.Redirect_Address[i*PC_WIDTH +: PC_WIDTH];
      end
    end
  end

  always_comb begin
    pc_next = pc_q;
    if (state == RUN && !bus.Stall) begin
      if (pend_vld)
        pc_next = pend_addr;
      else if (any_redir)
        pc_next = sel_addr;
      else
        pc_next = pc_q + PC_WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= START;
      pc_q      <= RESET_PC;
      pc_vld    <= 1'b0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
    end else begin
      case (state)
        START: begin
          state  <= RUN;
          pc_vld <= 1'b1;
          if (any_redir && !pend_vld) begin
            pend_vld  <= 1'b1;
            pend_addr <= sel_addr;
          end
        end
        RUN: begin
          pc_q <= pc_next;
          if (!bus.Stall) begin
            pend_vld <= 1'b0;
          end else if (any_redir && !pend_vld) begin
            pend_vld  <= 1'b1;
            pend_addr <= sel_addr;
          end
        end
        default: state <= START;
      endcase
    end
  end

  assign bus.PC_Out           = pc_q;
  assign bus.PC_Next          = pc_next;
  assign bus.PC_Valid         = pc_vld;
  assign bus.Redirect_Pending = pend_vld;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, stepping, wrap, priority,
// stall buffering, pending-vs-live, and reset with a pending redirect.
module tb_pc_sequencer;

  logic Clk = 1'b0;
  logic Reset;

  int n_checks = 0;
  int n_fails  = 0;

  pc_sequencer_if #(.PC_WIDTH(16), .NUM_REDIRECT(2)) bus ();

  pc_sequencer #(
    .PC_WIDTH(16), .PC_STEP(3), .NUM_REDIRECT(2), .RESET_PC(16'h0000)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic stall, input logic [1:0] vld,
                       input logic [15:0] a0, input logic [15:0] a1);
    bus.Stall            = stall;
    bus.Redirect_Valid   = vld;
    bus.Redirect_Address = {a1, a0};
  endtask

  task automatic check_state(input string tag, input logic [15:0] pc,
                             input logic v, input logic p);
    check({tag, "_pc"},      bus.PC_Out,           pc);
    check({tag, "_valid"},   {15'd0, bus.PC_Valid}, {15'd0, v});
    check({tag, "_pending"}, {15'd0, bus.Redirect_Pending}, {15'd0, p});
  endtask

  initial begin
    Reset = 1'b1;
    drive(1'b0, 2'b00, 16'h0, 16'h0);

    // Reset sequence
    tick();
    check_state("rst1", 16'h0000, 1'b0, 1'b0);
    tick();
    check_state("rst2", 16'h0000, 1'b0, 1'b0);
    Reset = 1'b0;
    #1;
    check("start_next", bus.PC_Next, 16'h0000);
    tick();
    check_state("run0", 16'h0000, 1'b1, 1'b0);
    check("run0_next", bus.PC_Next, 16'h0003);
    tick();
    check("seq3", bus.PC_Out, 16'h0003);
    tick();
    check("seq6", bus.PC_Out, 16'h0006);
    tick();
    check("seq9", bus.PC_Out, 16'h0009);

    // Wrap-around through 0xFFFE
    drive(1'b0, 2'b01, 16'hFFFB, 16'h0);
    tick();
    check("wrap_fffb", bus.PC_Out, 16'hFFFB);
    drive(1'b0, 2'b00, 16'h0, 16'h0);
    tick();
    check("wrap_fffe", bus.PC_Out, 16'hFFFE);
    #1;
    check("wrap_next", bus.PC_Next, 16'h0001);
    tick();
    check("wrap_0001", bus.PC_Out, 16'h0001);

    // Priority
    drive(1'b0, 2'b11, 16'h0100, 16'h0200);
    tick();
    check("prio_both", bus.PC_Out, 16'h0100);
    drive(1'b0, 2'b10, 16'h0100, 16'h0200);
    tick();
    check("prio_ch1", bus.PC_Out, 16'h0200);

    // X on an invalid channel must not reach the outputs
    drive(1'b0, 2'b10, 16'h0, 16'h0222);
    bus.Redirect_Address[15:0] = 16'hxxxx;
    #1;
    check("xmask_next", bus.PC_Next, 16'h0222);
    tick();
    check("xmask_pc", bus.PC_Out, 16'h0222);

    // Stall buffering from PC 0x0030
    drive(1'b0, 2'b01, 16'h0030, 16'h0);
    tick();
    check("to_0030", bus.PC_Out, 16'h0030);
    drive(1'b1, 2'b10, 16'h0, 16'h0400);
    #1;
    check("stall1_next", bus.PC_Next, 16'h0030);
    tick();
    check_state("stall2", 16'h0030, 1'b1, 1'b1);
    drive(1'b1, 2'b01, 16'h0500, 16'h0);
    tick();
    check_state("stall3", 16'h0030, 1'b1, 1'b1);
    drive(1'b1, 2'b00, 16'h0, 16'h0);
    tick();
    check_state("stall_end", 16'h0030, 1'b1, 1'b1);
    drive(1'b0, 2'b00, 16'h0, 16'h0);
    #1;
    check("unstall_next", bus.PC_Next, 16'h0400);
    tick();
    check_state("pend_taken", 16'h0400, 1'b1, 1'b0);
    tick();
    check("pend_step", bus.PC_Out, 16'h0403);

    // Pending redirect beats a live one arriving as Stall drops
    drive(1'b1, 2'b01, 16'h0400, 16'h0);
    tick();
    check_state("pvl_hold", 16'h0403, 1'b1, 1'b1);
    drive(1'b0, 2'b01, 16'h0600, 16'h0);
    #1;
    check("pvl_next", bus.PC_Next, 16'h0400);
    tick();
    check_state("pvl_pc", 16'h0400, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 16'h0, 16'h0);
    tick();
    check("pvl_step", bus.PC_Out, 16'h0403);

    // Reset while stalled with a pending redirect
    drive(1'b1, 2'b10, 16'h0, 16'h0800);
    tick();
    check_state("mid_pend", 16'h0403, 1'b1, 1'b1);
    Reset = 1'b1;
    drive(1'b1, 2'b00, 16'h0, 16'h0);
    tick();
    check_state("mid_rst", 16'h0000, 1'b0, 1'b0);
    Reset = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 16'h0);
    tick();
    check_state("mid_start", 16'h0000, 1'b1, 1'b0);
    tick();
    check("mid_seq3", bus.PC_Out, 16'h0003);
    tick();
    check("mid_seq6", bus.PC_Out, 16'h0006);

    // Redirect presented in START is buffered, then taken
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive(1'b1, 2'b10, 16'h0, 16'h0123);
    #1;
    check("start_hold_next", bus.PC_Next, 16'h0000);
    tick();
    check_state("start_cap", 16'h0000, 1'b1, 1'b1);
    drive(1'b0, 2'b00, 16'h0, 16'h0);
    tick();
    check_state("start_take", 16'h0123, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
